// File: rtl/mux_arb.sv
// mux_arb: N-channel registered multiplexer with per-channel valid/ready,
// fixed-select or round-robin arbitration, and a single output register.
module mux_arb #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       o_ready,
  input  logic                      i_mode,
  input  logic [SELW-1:0]           i_sel,
  output logic [WIDTH-1:0]          o_data,
  output logic [SELW-1:0]           o_chan,
  output logic                      o_valid,
  input  logic                      i_ready
);

  localparam logic [SELW:0]   CH_NUM  = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] CH_LAST = SELW'(CHANNELS-1);

  logic [WIDTH-1:0]    data_q, data_d;
  logic [SELW-1:0]     chan_q, chan_d;
  logic                valid_q, valid_d;
  logic [SELW-1:0]     ptr_q, ptr_d;

  logic                load;
  logic [CHANNELS-1:0] fix_oh;
  logic [CHANNELS-1:0] rr_oh;
  logic [CHANNELS-1:0] grant_oh;
  logic                grant_any;
  logic [SELW-1:0]     grant_idx;
  logic [SELW:0]       rr_idx;
  logic                rr_found;

  assign load = !valid_q || i_ready;

  // A select value beyond the last channel matches no k and grants nothing.
  always_comb begin
    fix_oh = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (i_sel == SELW'(k)) begin
        fix_oh[k] = i_valid[k];
      end
    end
  end

  // Scan ptr, ptr+1, ... with explicit wrap so CHANNELS need not be 2^n.
  always_comb begin
    rr_oh    = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rr_idx = {1'b0, ptr_q} + (SELW+1)'(i);
      if (rr_idx >= CH_NUM) begin
        rr_idx = rr_idx - CH_NUM;
      end
      if (!rr_found && i_valid[rr_idx[SELW-1:0]]) begin
        rr_oh[rr_idx[SELW-1:0]] = 1'b1;
        rr_found                = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (load && i_rst_n) begin
      grant_oh = i_mode ? rr_oh : fix_oh;
    end
  end

  always_comb begin
    grant_any = |grant_oh;
    grant_idx = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_oh[k]) begin
        grant_idx = SELW'(k);
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (grant_any) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (grant_oh[k]) begin
            data_d = i_data[k*WIDTH +: WIDTH];
          end
        end
        chan_d  = grant_idx;
        valid_d = 1'b1;
        ptr_d   = (grant_idx == CH_LAST) ? '0 : grant_idx + SELW'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_ready = grant_oh;
  assign o_data  = data_q;
  assign o_chan  = chan_q;
  assign o_valid = valid_q;

endmodule
